// File: rtl/svi_count_arbiter_pkg.sv
// Shared types and defaults for the counter-sharing arbiter.
package svi_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_RUN,
        S_DRAIN
    } svi_arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 255;

    // Index following idx on a ring of n positions.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/svi_count_arbiter_if.sv
// Requester-side and counter-side signals of the arbiter, bundled.
// master: the arbiter itself. slave: requesters plus the counter sub-block.
interface svi_count_arbiter_if
    import svi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic [NUM_REQ-1:0]       err;
    logic                     busy;
    logic                     start;
    logic                     svi_enable;
    logic [CNT_W-1:0]         count;
    logic                     svi_error;
    logic [CNT_W-1:0]         svi_count2;
    logic [CNT_W-1:0]         last_count2;

    modport master (
        input  req, req_len, count, svi_error, svi_count2,
        output gnt, done, err, busy, start, svi_enable, last_count2
    );

    modport slave (
        output req, req_len, count, svi_error, svi_count2,
        input  gnt, done, err, busy, start, svi_enable, last_count2
    );

endinterface

// File: rtl/svi_count_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_pick
    import svi_arb_pkg::*;
#(
    parameter int N     = DEF_NUM_REQ,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    // Walk ptr, ptr+1, ... with wraparound; the first hit wins.
    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                idx       = PTR_W'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/svi_count_arbiter.sv
// Shares one counter sub-block between NUM_REQ requesters, one job at a time.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | no job; wait for any request
//  S_ARB   | pick owner round-robin, latch its length (len 0 -> DRAIN)
//  S_START | grant owner, one-cycle start pulse to the counter
//  S_RUN   | enable held; exit on error/req drop, count>=len, or watchdog
//  S_DRAIN | enable low, capture count2, pulse done or err to the owner
module svi_count_arbiter
    import svi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    svi_count_arbiter_if.master bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    // wd counts completed RUN cycles, so the last permitted one sees TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    svi_arb_state_t     state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   len;
    logic [WD_W-1:0]    wd;

    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] err_q;
    logic               busy_q;
    logic               start_q;
    logic               en_q;
    logic [CNT_W-1:0]   last_q;

    logic [NUM_REQ-1:0] pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [CNT_W-1:0]   pick_len;
    logic               run_abort;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign pick_len  = bus.req_len[int'(pick_idx)*CNT_W +: CNT_W];
    // An error from the counter or the owner giving up both abort the job.
    assign run_abort = bus.svi_error || !bus.req[owner];

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.start       = start_q;
    assign bus.svi_enable  = en_q;
    assign bus.last_count2 = last_q;

    // Job sequencer; every output is registered on the state transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            len     <= '0;
            wd      <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            en_q    <= 1'b0;
            last_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        state  <= S_ARB;
                        busy_q <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (!pick_valid) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        owner  <= pick_idx;
                        len    <= pick_len;
                        rr_ptr <= PTR_W'(rr_wrap(int'(pick_idx), NUM_REQ));
                        if (pick_len == '0) begin
                            err_q <= pick_oh;
                            state <= S_DRAIN;
                        end else begin
                            gnt_q   <= pick_oh;
                            start_q <= 1'b1;
                            state   <= S_START;
                        end
                    end
                end
                S_START: begin
                    start_q <= 1'b0;
                    en_q    <= 1'b1;
                    wd      <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    wd <= wd + 1'b1;
                    if (run_abort) begin
                        en_q  <= 1'b0;
                        err_q <= gnt_q;
                        state <= S_DRAIN;
                    end else if (bus.count >= len) begin
                        en_q   <= 1'b0;
                        done_q <= gnt_q;
                        state  <= S_DRAIN;
                    end else if (wd == WD_LAST) begin
                        en_q  <= 1'b0;
                        err_q <= gnt_q;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    done_q <= '0;
                    err_q  <= '0;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                    last_q <= bus.svi_count2;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_svi_count_arbiter.sv
module tb_svi_count_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    svi_count_arbiter_if #(.NUM_REQ(N), .CNT_W(W)) bus ();

    svi_count_arbiter #(.NUM_REQ(N), .CNT_W(W), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Counter sub-block model: cleared by start, counts while enabled.
    logic [W-1:0] cnt;
    bit           stuck = 0;
    bit           err_en = 0;
    int           err_at = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        cnt <= '0;
        else if (bus.start)                  cnt <= '0;
        else if (bus.svi_enable && !stuck)   cnt <= cnt + 1'b1;
    end

    assign bus.count     = cnt;
    assign bus.svi_error = err_en && bus.svi_enable && (int'(cnt) == err_at);

    initial begin
        #500000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1, "global timeout");
    end

    task automatic set_len(input int i, input int v);
        bus.req_len[i*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        bus.req = '0;
        bus.req_len = '0;
        bus.svi_count2 = '0;
        stuck = 0;
        err_en = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Follows one job from the current negedge until a done/err pulse is seen.
    task automatic observe(input bit drop,
                           output int n_start, output int n_en,
                           output logic [N-1:0] g, output logic [N-1:0] d,
                           output logic [N-1:0] e, output int c_start,
                           output int c_end, output int viol, output bit to);
        n_start = 0; n_en = 0; g = '0; d = '0; e = '0;
        c_start = -1; c_end = -1; viol = 0; to = 1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (!$onehot0(bus.gnt) || ($countones({bus.done, bus.err}) > 1)) viol++;
            if (bus.start) begin
                n_start++;
                if (c_start < 0) begin
                    c_start = c;
                    g = bus.gnt;
                end
            end
            if (bus.svi_enable) n_en++;
            if (|{bus.done, bus.err}) begin
                d = bus.done;
                e = bus.err;
                c_end = c;
                if (drop) bus.req = bus.req & ~(bus.done | bus.err);
                to = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.req = '0;
        bus.req_len = '0;
        bus.svi_count2 = '0;
        @(negedge clk);
        total++;
        if ({bus.gnt, bus.done, bus.err} !== '0) begin
            bad++; $display("FAIL reset_vec got=%b want=0", {bus.gnt, bus.done, bus.err});
        end
        total++;
        if ({bus.busy, bus.start, bus.svi_enable} !== 3'b000) begin
            bad++; $display("FAIL reset_ctl got=%b want=000", {bus.busy, bus.start, bus.svi_enable});
        end
        total++;
        if (bus.last_count2 !== '0) begin
            bad++; $display("FAIL reset_lc2 got=%0h want=0", bus.last_count2);
        end
    endtask

    task automatic test_single();
        int ns, ne, cs, ce, vi; logic [N-1:0] g, d, e; bit to;
        do_reset();
        bus.svi_count2 = 8'hA5;
        set_len(0, 5);
        bus.req = 4'b0001;
        observe(1, ns, ne, g, d, e, cs, ce, vi, to);
        total++; if (to !== 0) begin bad++; $display("FAIL single_to got=%0d want=0", to); end
        total++; if (cs !== 2) begin bad++; $display("FAIL single_start_cyc got=%0d want=2", cs); end
        total++; if (ns !== 1) begin bad++; $display("FAIL single_nstart got=%0d want=1", ns); end
        total++; if (g !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", g); end
        total++; if (ne !== 6) begin bad++; $display("FAIL single_nen got=%0d want=6", ne); end
        total++; if ({d, e} !== 8'b0001_0000) begin bad++; $display("FAIL single_de got=%b want=00010000", {d, e}); end
        total++; if (ce !== 9) begin bad++; $display("FAIL single_end_cyc got=%0d want=9", ce); end
        total++; if (vi !== 0) begin bad++; $display("FAIL single_onehot got=%0d want=0", vi); end
        @(negedge clk);
        total++; if ({bus.gnt, bus.busy} !== 5'b0) begin bad++; $display("FAIL single_idle got=%b want=0", {bus.gnt, bus.busy}); end
        total++; if (bus.last_count2 !== 8'hA5) begin bad++; $display("FAIL single_lc2 got=%0h want=a5", bus.last_count2); end
    endtask

    task automatic test_round_robin();
        int ns, ne, cs, ce, vi; logic [N-1:0] g, d, e; bit to;
        int ptr, exp_o;
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 3);
        bus.req = 4'b1111;
        ptr = 0;
        for (int j = 0; j < 5; j++) begin
            exp_o = -1;
            for (int k = 0; k < N; k++)
                if (exp_o < 0 && bus.req[(ptr + k) % N]) exp_o = (ptr + k) % N;
            ptr = (exp_o + 1) % N;
            observe(0, ns, ne, g, d, e, cs, ce, vi, to);
            total++; if (to !== 0) begin bad++; $display("FAIL rr_to job=%0d got=%0d want=0", j, to); end
            total++; if (g !== 4'(1 << exp_o)) begin bad++; $display("FAIL rr_gnt job=%0d got=%b want=%0d", j, g, exp_o); end
            total++; if (d !== 4'(1 << exp_o)) begin bad++; $display("FAIL rr_done job=%0d got=%b want=%0d", j, d, exp_o); end
            total++; if (ne !== 4) begin bad++; $display("FAIL rr_nen job=%0d got=%0d want=4", j, ne); end
            total++; if (vi !== 0) begin bad++; $display("FAIL rr_onehot job=%0d got=%0d want=0", j, vi); end
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_error();
        int ns, ne, cs, ce, vi; logic [N-1:0] g, d, e; bit to;
        int lens[2] = '{10, 6};
        int ats[2]  = '{4, 6};
        for (int j = 0; j < 2; j++) begin
            set_len(2, lens[j]);
            err_en = 1;
            err_at = ats[j];
            bus.req = 4'b0100;
            observe(1, ns, ne, g, d, e, cs, ce, vi, to);
            total++; if (to !== 0) begin bad++; $display("FAIL error_to case=%0d got=%0d want=0", j, to); end
            total++; if ({d, e} !== 8'b0000_0100) begin bad++; $display("FAIL error_de case=%0d got=%b want=00000100", j, {d, e}); end
            total++; if (ne !== ats[j] + 1) begin bad++; $display("FAIL error_nen case=%0d got=%0d want=%0d", j, ne, ats[j] + 1); end
            @(negedge clk);
            total++; if ({bus.svi_enable, bus.busy} !== 2'b00) begin bad++; $display("FAIL error_idle case=%0d got=%b want=00", j, {bus.svi_enable, bus.busy}); end
            err_en = 0;
        end
    endtask

    task automatic test_timeout();
        int ns, ne, cs, ce, vi; logic [N-1:0] g, d, e; bit to;
        stuck = 1;
        set_len(1, 200);
        bus.req = 4'b0010;
        observe(1, ns, ne, g, d, e, cs, ce, vi, to);
        total++; if (to !== 0) begin bad++; $display("FAIL timeout_to got=%0d want=0", to); end
        total++; if ({d, e} !== 8'b0000_0010) begin bad++; $display("FAIL timeout_de got=%b want=00000010", {d, e}); end
        total++; if (ne !== TO) begin bad++; $display("FAIL timeout_nen got=%0d want=%0d", ne, TO); end
        total++; if (ce !== TO + 3) begin bad++; $display("FAIL timeout_end_cyc got=%0d want=%0d", ce, TO + 3); end
        stuck = 0;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        int ns, ne, cs, ce, vi; logic [N-1:0] g, d, e; bit to;
        set_len(0, 0);
        bus.req = 4'b0001;
        observe(1, ns, ne, g, d, e, cs, ce, vi, to);
        total++; if (to !== 0) begin bad++; $display("FAIL zero_to got=%0d want=0", to); end
        total++; if (ns !== 0) begin bad++; $display("FAIL zero_nstart got=%0d want=0", ns); end
        total++; if ({d, e} !== 8'b0000_0001) begin bad++; $display("FAIL zero_de got=%b want=00000001", {d, e}); end
        total++; if (ce !== 2) begin bad++; $display("FAIL zero_end_cyc got=%0d want=2", ce); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%b want=0", bus.busy); end
    endtask

    task automatic test_owner_drop();
        int ne; logic [N-1:0] d, e; bit to;
        ne = 0; d = '0; e = '0; to = 1;
        set_len(3, 40);
        bus.req = 4'b1000;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.svi_enable) ne++;
            if (ne == 3) bus.req = '0;
            if (|{bus.done, bus.err}) begin
                d = bus.done; e = bus.err; to = 0;
                break;
            end
        end
        total++; if (to !== 0) begin bad++; $display("FAIL drop_to got=%0d want=0", to); end
        total++; if ({d, e} !== 8'b0000_1000) begin bad++; $display("FAIL drop_de got=%b want=00001000", {d, e}); end
        total++; if (ne !== 3) begin bad++; $display("FAIL drop_nen got=%0d want=3", ne); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int ns, ne, cs, ce, vi; logic [N-1:0] g, d, e; bit to;
        set_len(2, 50);
        bus.req = 4'b0100;
        for (int c = 0; c < 50 && !bus.svi_enable; c++) @(negedge clk);
        total++; if (bus.svi_enable !== 1'b1) begin bad++; $display("FAIL arst_run got=%b want=1", bus.svi_enable); end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({bus.svi_enable, bus.start, bus.busy, bus.gnt} !== 7'b0) begin
            bad++; $display("FAIL arst_drop got=%b want=0", {bus.svi_enable, bus.start, bus.busy, bus.gnt});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) set_len(i, 2);
        bus.req = 4'b1111;
        observe(1, ns, ne, g, d, e, cs, ce, vi, to);
        total++; if (g !== 4'b0001) begin bad++; $display("FAIL arst_ptr got=%b want=0001", g); end
        total++; if (cs !== 2) begin bad++; $display("FAIL arst_start_cyc got=%0d want=2", cs); end
        bus.req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int ns, ne, cs, ce, vi; logic [N-1:0] g, d, e; bit to;
        int ptr, own, L, exp_en, exp_ns, run_end;
        int lens[N];
        bit exp_ok;
        logic [N-1:0] mask, oh;
        logic [W-1:0] c2;
        do_reset();
        ptr = 0;
        for (int j = 0; j < 40; j++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                lens[i] = $urandom_range(0, 20);
                set_len(i, lens[i]);
            end
            err_en = ($urandom_range(0, 2) == 0);
            err_at = $urandom_range(0, 20);
            c2 = W'($urandom);
            bus.svi_count2 = c2;

            own = -1;
            for (int k = 0; k < N; k++)
                if (own < 0 && mask[(ptr + k) % N]) own = (ptr + k) % N;
            ptr = (own + 1) % N;
            oh = 4'(1 << own);
            L = lens[own];
            if (L == 0) begin
                exp_ok = 0; exp_en = 0; exp_ns = 0;
            end else begin
                exp_ns = 1;
                run_end = (L + 1 < TO) ? L + 1 : TO;
                if (err_en && err_at + 1 <= run_end) begin
                    exp_ok = 0; exp_en = err_at + 1;
                end else if (L + 1 <= TO) begin
                    exp_ok = 1; exp_en = L + 1;
                end else begin
                    exp_ok = 0; exp_en = TO;
                end
            end

            bus.req = mask;
            observe(1, ns, ne, g, d, e, cs, ce, vi, to);
            bus.req = '0;
            total++; if (to !== 0) begin bad++; $display("FAIL rand_to job=%0d got=%0d want=0", j, to); end
            total++;
            if ({d, e} !== (exp_ok ? {oh, 4'b0} : {4'b0, oh})) begin
                bad++; $display("FAIL rand_de job=%0d got=%b want_owner=%0d ok=%0d", j, {d, e}, own, exp_ok);
            end
            total++; if (ne !== exp_en) begin bad++; $display("FAIL rand_nen job=%0d got=%0d want=%0d", j, ne, exp_en); end
            total++; if (ns !== exp_ns) begin bad++; $display("FAIL rand_nstart job=%0d got=%0d want=%0d", j, ns, exp_ns); end
            total++; if (vi !== 0) begin bad++; $display("FAIL rand_onehot job=%0d got=%0d want=0", j, vi); end
            @(negedge clk);
            total++; if (bus.last_count2 !== c2) begin bad++; $display("FAIL rand_lc2 job=%0d got=%0h want=%0h", j, bus.last_count2, c2); end
        end
        err_en = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_error();
        test_timeout();
        test_zero_len();
        test_owner_drop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
